// File: rtl/conware_pkg.sv
// Shared types and default widths for the conware generation controller.
package conware_pkg;

  // Default configuration widths for the generation count and row index.
  localparam int GEN_W_DEF = 8;
  localparam int ROW_W_DEF = 8;

  // Width of the frame counter and the statistics counters.
  localparam int CNT_W = 32;

  // Controller states: wait for enable, take a row, pulse a step, wait for
  // the shredder, present the row downstream.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_WAIT = 3'd3,
    ST_EMIT = 3'd4
  } state_t;

endpackage

// File: rtl/conware_gen_ctrl_if.sv
// Row handshake bundle between axis2buffer, shredder_array, buffer2axis and
// the generation controller. The master side is the controller.
interface conware_gen_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic in_last;
  logic step_en;
  logic step_done;
  logic out_valid;
  logic out_ready;
  logic out_last;

  modport master (
    input  in_valid, in_last, step_done, out_ready,
    output in_ready, step_en, out_valid, out_last
  );

  modport slave (
    output in_valid, in_last, step_done, out_ready,
    input  in_ready, step_en, out_valid, out_last
  );

endinterface

// File: rtl/conware_step_timer.sv
// Loadable down-counter used as the per-step watchdog. expired_o is high
// whenever the count sits at zero; the count never wraps below zero.
module conware_step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; otherwise count down toward zero while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadValue_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/conware_gen_ctrl.sv
// Sequencer for the conware row datapath: accepts a row, issues the
// configured number of generation steps, then presents the row downstream
// while tracking row position, frame count and sticky error flags.
// Optional statistics outputs are built when CONWARE_GEN_STATS_EN is defined.
module conware_gen_ctrl
  import conware_pkg::*;
#(
  parameter int HEIGHT       = 1,
  parameter int GEN_W        = GEN_W_DEF,
  parameter int ROW_W        = ROW_W_DEF,
  parameter int STEP_TIMEOUT = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_enable,
  input  logic [GEN_W-1:0]  cfg_gens,
  input  logic              err_clr,
  conware_gen_ctrl_if.master bus,
  output logic [ROW_W-1:0]  row_idx,
  output logic [CNT_W-1:0]  frame_count,
  output logic              err_frame,
  output logic              err_timeout,
`ifdef CONWARE_GEN_STATS_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  step_total,
`endif
  output logic              busy
);

  localparam int TIMER_W = (STEP_TIMEOUT < 2) ? 1 : $clog2(STEP_TIMEOUT + 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(HEIGHT - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(STEP_TIMEOUT);

  state_t           state_q,       state_d;
  logic [GEN_W-1:0] remaining_q,   remaining_d;
  logic             lastLatched_q, lastLatched_d;
  logic [ROW_W-1:0] rowIdx_q,      rowIdx_d;
  logic [CNT_W-1:0] frameCount_q,  frameCount_d;
  logic             errFrame_q,    errFrame_d;
  logic             errTimeout_q,  errTimeout_d;

  logic isLastRow;
  logic timerExpired;

  assign isLastRow = (rowIdx_q == LAST_ROW);

  conware_step_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk        (ACLK),
    .rst        (ARESET),
    .load_i     (state_q == ST_STEP),
    .loadValue_i(TIMER_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .expired_o  (timerExpired)
  );

  // Next-state logic: FSM transitions, row bookkeeping and error setting.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    lastLatched_d = lastLatched_q;
    rowIdx_d      = rowIdx_q;
    frameCount_d  = frameCount_q;
    errFrame_d    = errFrame_q & ~err_clr;
    errTimeout_d  = errTimeout_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          lastLatched_d = bus.in_last;
          remaining_d   = cfg_gens;
          state_d       = (cfg_gens == '0) ? ST_EMIT : ST_STEP;
          if (bus.in_last != isLastRow) begin
            errFrame_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.step_done) begin
          remaining_d = remaining_q - GEN_W'(1);
          state_d     = (remaining_q == GEN_W'(1)) ? ST_EMIT : ST_STEP;
        end else if (timerExpired) begin
          errTimeout_d = 1'b1;
          remaining_d  = '0;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (isLastRow || lastLatched_q) begin
            rowIdx_d     = '0;
            frameCount_d = frameCount_q + CNT_W'(1);
          end else begin
            rowIdx_d = rowIdx_q + ROW_W'(1);
          end
          state_d = cfg_enable ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset drops any in-flight row.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      lastLatched_q <= 1'b0;
      rowIdx_q      <= '0;
      frameCount_q  <= '0;
      errFrame_q    <= 1'b0;
      errTimeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      lastLatched_q <= lastLatched_d;
      rowIdx_q      <= rowIdx_d;
      frameCount_q  <= frameCount_d;
      errFrame_q    <= errFrame_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.step_en   = (state_q == ST_STEP);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_last  = (state_q == ST_EMIT) && isLastRow;

  assign row_idx     = rowIdx_q;
  assign frame_count = frameCount_q;
  assign err_frame   = errFrame_q;
  assign err_timeout = errTimeout_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef CONWARE_GEN_STATS_EN
  logic [CNT_W-1:0] stallCycles_q;
  logic [CNT_W-1:0] stepTotal_q;

  // Count downstream stall cycles, saturating so the figure never wraps.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stallCycles_q <= '0;
    end else if (err_clr) begin
      stallCycles_q <= '0;
    end else if ((state_q == ST_EMIT) && !bus.out_ready && (stallCycles_q != '1)) begin
      stallCycles_q <= stallCycles_q + CNT_W'(1);
    end
  end

  // Count every completed generation step; this one wraps.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stepTotal_q <= '0;
    end else if (err_clr) begin
      stepTotal_q <= '0;
    end else if ((state_q == ST_WAIT) && bus.step_done) begin
      stepTotal_q <= stepTotal_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stallCycles_q;
  assign step_total   = stepTotal_q;
`endif

endmodule

// File: tb/tb_conware_gen_ctrl.sv
// Scoreboard bench for conware_gen_ctrl with HEIGHT=4 and STEP_TIMEOUT=5.
// Stimulus pushes the expected emit for each row; a monitor pops and checks.
module tb_conware_gen_ctrl;
  import conware_pkg::*;

  localparam int HEIGHT       = 4;
  localparam int GEN_W        = 8;
  localparam int ROW_W        = 8;
  localparam int STEP_TIMEOUT = 5;

  typedef struct {
    logic       last;
    logic [7:0] row;
    int         latency;
    int         steps;
  } exp_t;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cfgEnable;
  logic [GEN_W-1:0]  cfgGens;
  logic              errClr;
  logic [ROW_W-1:0]  rowIdx;
  logic [CNT_W-1:0]  frameCount;
  logic              errFrame;
  logic              errTimeout;
  logic              busy;
`ifdef CONWARE_GEN_STATS_EN
  logic [CNT_W-1:0]  stallCycles;
  logic [CNT_W-1:0]  stepTotal;
`endif

  conware_gen_ctrl_if bus ();

  conware_gen_ctrl #(
    .HEIGHT      (HEIGHT),
    .GEN_W       (GEN_W),
    .ROW_W       (ROW_W),
    .STEP_TIMEOUT(STEP_TIMEOUT)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cfg_enable  (cfgEnable),
    .cfg_gens    (cfgGens),
    .err_clr     (errClr),
    .bus         (bus),
    .row_idx     (rowIdx),
    .frame_count (frameCount),
    .err_frame   (errFrame),
    .err_timeout (errTimeout),
`ifdef CONWARE_GEN_STATS_EN
    .stall_cycles(stallCycles),
    .step_total  (stepTotal),
`endif
    .busy        (busy)
  );

  always #5 ACLK = ~ACLK;

  int   nTests = 0;
  int   nFail  = 0;
  int   cycle  = 0;
  exp_t expQ[$];
  bit   autoResp = 1'b0;
  bit   pending = 1'b0;
  bit   seenValid = 1'b0;
  int   acceptCycle = 0;
  int   firstValid = 0;
  int   stepCount = 0;
  int   inReadyViol = 0;
  logic sampledStepEn = 1'b0;

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Offer one row, record its expected emit, and return once it is accepted.
  task automatic applyStimulus(input logic inLast, input logic [7:0] gens, input logic expLast,
                               input logic [7:0] expRow, input int expLat, input int expSteps);
    exp_t e;
    bit accepted;
    accepted  = 1'b0;
    e.last    = expLast;
    e.row     = expRow;
    e.latency = expLat;
    e.steps   = expSteps;
    expQ.push_back(e);
    @(posedge ACLK); #1;
    bus.in_valid = 1'b1;
    bus.in_last  = inLast;
    cfgGens      = gens;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge ACLK);
      if (bus.in_ready) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    cfgGens      = 8'd7;
  endtask

  // Wait for every expected row to be emitted, bounded.
  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ACLK);
      if (expQ.size() == 0) done = 1'b1;
    end
    if (!done) checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
    @(posedge ACLK); #1;
  endtask

  // Pulse err_clr for one cycle.
  task automatic pulseErrClr();
    @(posedge ACLK); #1;
    errClr = 1'b1;
    @(posedge ACLK); #1;
    errClr = 1'b0;
  endtask

  // Cycle counter used for latency measurement.
  initial forever begin
    @(posedge ACLK);
    cycle++;
  end

  // Shredder model: answer step_en on the following cycle when enabled.
  initial forever begin
    @(negedge ACLK);
    sampledStepEn = bus.step_en;
    @(posedge ACLK); #1;
    bus.step_done = autoResp & sampledStepEn;
  end

  // Monitor: track accept time and steps, check each emitted row.
  initial forever begin
    @(negedge ACLK);
    if (ARESET) begin
      pending   = 1'b0;
      seenValid = 1'b0;
    end else begin
      if (pending && bus.step_en)  stepCount++;
      if (pending && bus.in_ready) inReadyViol++;
      if (bus.out_valid && !seenValid) begin
        firstValid = cycle;
        seenValid  = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected emit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("emit out_last", 32'(bus.out_last), 32'(e.last));
          checkOutput("emit row_idx", 32'(rowIdx), 32'(e.row));
          checkOutput("emit latency", 32'(firstValid - acceptCycle), 32'(e.latency));
          checkOutput("emit step pulses", 32'(stepCount), 32'(e.steps));
          checkOutput("in_ready while busy", 32'(inReadyViol), 32'd0);
        end
        seenValid = 1'b0;
        pending   = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        acceptCycle = cycle;
        pending     = 1'b1;
        stepCount   = 0;
        inReadyViol = 0;
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int badValid;
    int badLast;
    int badReady;
    bit sawValid;

    ARESET        = 1'b1;
    cfgEnable     = 1'b0;
    cfgGens       = '0;
    errClr        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.step_done = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset step_en", 32'(bus.step_en), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset row_idx", 32'(rowIdx), 32'd0);
    checkOutput("reset frame_count", frameCount, 32'd0);
    checkOutput("reset err_frame", 32'(errFrame), 32'd0);
    checkOutput("reset err_timeout", 32'(errTimeout), 32'd0);
    ARESET    = 1'b0;
    cfgEnable = 1'b1;
    autoResp  = 1'b1;

    $display("[TB] full frame, passthrough");
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd1, 1, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd2, 1, 0);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd3, 1, 0);
    waitDrain();
    checkOutput("frame1 frame_count", frameCount, 32'd1);
    checkOutput("frame1 row_idx", 32'(rowIdx), 32'd0);
    checkOutput("frame1 err_frame", 32'(errFrame), 32'd0);
    checkOutput("frame1 err_timeout", 32'(errTimeout), 32'd0);

    $display("[TB] three generations");
    applyStimulus(1'b0, 8'd3, 1'b0, 8'd0, 7, 3);
    waitDrain();
    checkOutput("gens3 row_idx", 32'(rowIdx), 32'd1);

    $display("[TB] early TLAST");
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd1, 1, 0);
    waitDrain();
    checkOutput("early last err_frame", 32'(errFrame), 32'd1);
    checkOutput("early last row_idx", 32'(rowIdx), 32'd0);
    checkOutput("early last frame_count", frameCount, 32'd2);
    pulseErrClr();
    checkOutput("err_clr err_frame", 32'(errFrame), 32'd0);

    $display("[TB] step timeout");
    autoResp = 1'b0;
    applyStimulus(1'b0, 8'd2, 1'b0, 8'd0, 8, 1);
    waitDrain();
    checkOutput("timeout err_timeout", 32'(errTimeout), 32'd1);
    checkOutput("timeout back to load", 32'(bus.in_ready), 32'd1);
    checkOutput("timeout row_idx", 32'(rowIdx), 32'd1);
    pulseErrClr();
    checkOutput("err_clr err_timeout", 32'(errTimeout), 32'd0);
    autoResp = 1'b1;

    $display("[TB] downstream stall");
    applyStimulus(1'b0, 8'd1, 1'b0, 8'd1, 3, 1);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd2, 1, 0);
    waitDrain();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd3, 1, 0);
    sawValid = 1'b0;
    for (int i = 0; i < 50 && !sawValid; i++) begin
      @(negedge ACLK);
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("stall out_valid seen", 32'(sawValid), 32'd1);
    badValid = 0;
    badLast  = 0;
    badReady = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge ACLK);
      if (bus.out_valid !== 1'b1) badValid++;
      if (bus.out_last !== 1'b1)  badLast++;
      if (bus.in_ready !== 1'b0)  badReady++;
    end
    checkOutput("stall out_valid held", 32'(badValid), 32'd0);
    checkOutput("stall out_last held", 32'(badLast), 32'd0);
    checkOutput("stall in_ready low", 32'(badReady), 32'd0);
    @(posedge ACLK); #1;
    bus.out_ready = 1'b1;
    waitDrain();
    checkOutput("stall frame_count", frameCount, 32'd3);
`ifdef CONWARE_GEN_STATS_EN
    checkOutput("stats stall_cycles", stallCycles, 32'd10);
    checkOutput("stats step_total", stepTotal, 32'd1);
`endif

    $display("[TB] enable dropped mid-row");
    applyStimulus(1'b0, 8'd2, 1'b0, 8'd0, 5, 2);
    cfgEnable = 1'b0;
    waitDrain();
    checkOutput("disable busy", 32'(busy), 32'd0);
    checkOutput("disable in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("disable row_idx kept", 32'(rowIdx), 32'd1);

    $display("[TB] reset during wait");
    cfgEnable = 1'b1;
    autoResp  = 1'b0;
    applyStimulus(1'b0, 8'd1, 1'b0, 8'd1, 3, 1);
    @(posedge ACLK); #2;
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    ARESET = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset step_en", 32'(bus.step_en), 32'd0);
    checkOutput("async reset in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("async reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async reset row_idx", 32'(rowIdx), 32'd0);
    checkOutput("async reset frame_count", frameCount, 32'd0);
    expQ.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET   = 1'b0;
    autoResp = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1, 0);
    waitDrain();
    checkOutput("post-reset row_idx", 32'(rowIdx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
